// File: rtl/mux_seq_pkg.sv
// Shared types and default constants for the mux select sequencer.
//
// Contents:
//   state_e          - sequencer mode: StIdle, StScan, StManual
//   SelWDefault      - default select width (8 channels)
//   DivMaxDefault    - default prescaler terminal count
//   DbCyclesDefault  - default debounce stability length in clocks
package mux_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StScan   = 2'd1,
    StManual = 2'd2
  } state_e;

  localparam int unsigned SelWDefault     = 3;
  localparam int unsigned DivMaxDefault   = 4999999;
  localparam int unsigned DbCyclesDefault = 50000;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a debounce counter.
//
// The debounced level only follows the synchronised input after it has
// differed from the current debounced level for DB_CYCLES consecutive clocks,
// so the raw-edge-to-output latency is 2 + DB_CYCLES clocks.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   din  - asynchronous raw input
//   dout - synchronised, debounced level
module debounce_sync
  import mux_seq_pkg::*;
#(
  parameter int unsigned DB_W      = 16,
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees with the stable level;
  // any agreement restarts the stability window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/mux_sel_sequencer.sv
// Control stage feeding the 8-to-1 byte mux: debounces the enable switch and
// step button, and sequences the channel select either on a prescaled timer
// (auto_mode=1) or on each debounced button press (auto_mode=0).
//
// Optional feature: define MUX_SEQ_PINGPONG_EN to make sel sweep up to the
// last channel and back down to 0 without repeating endpoints. Without it sel
// simply counts up and wraps.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   sw_raw     - asynchronous enable switch
//   btn_raw    - asynchronous step button, active-high
//   auto_mode  - 1 = timed scan, 0 = manual step (synchronous)
//   sel        - channel select to mux Sel
//   sw_en      - debounced enable to mux SW
//   step_pulse - one-cycle high when sel changes
//   tick       - one-cycle prescaler wrap strobe
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned SEL_W     = SelWDefault,
  parameter int unsigned DIV_W     = 24,
  parameter int unsigned DIV_MAX   = DivMaxDefault,
  parameter int unsigned DB_W      = 16,
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_raw,
  input  logic             btn_raw,
  input  logic             auto_mode,
  output logic [SEL_W-1:0] sel,
  output logic             sw_en,
  output logic             step_pulse,
  output logic             tick
);

  localparam logic [SEL_W-1:0] SelLast = {SEL_W{1'b1}};

  logic sw_db, btn_db;

  debounce_sync #(
    .DB_W      (DB_W),
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_db (
    .clk  (clk),
    .rst  (rst),
    .din  (sw_raw),
    .dout (sw_db)
  );

  debounce_sync #(
    .DB_W      (DB_W),
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_db (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_raw),
    .dout (btn_db)
  );

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d, presc_base;
  logic [SEL_W-1:0]   sel_q, sel_d, sel_adv;
  logic               step_q, step_d;
  logic               btn_prev_q, btn_rise;
  logic               advance;
`ifdef MUX_SEQ_PINGPONG_EN
  logic               dir_q, dir_d, dir_adv;  // 0 = sweeping up, 1 = sweeping down
`endif

  // Mode is decided from this cycle's debounced enable and auto_mode so that a
  // falling enable or a mode change takes precedence over a same-cycle event.
  always_comb begin
    state_d = StIdle;
    if (sw_db) begin
      state_d = auto_mode ? StScan : StManual;
    end
  end

  assign btn_rise = btn_db & ~btn_prev_q;

  // Prescaler restarts from 0 on every entry to scan; held at 0 elsewhere.
  always_comb begin
    presc_base = (state_q == StScan) ? presc_q : '0;
    tick       = (state_d == StScan) && (presc_base == DIV_W'(DIV_MAX));
    presc_d    = '0;
    if ((state_d == StScan) && !tick) begin
      presc_d = presc_base + DIV_W'(1);
    end
  end

  always_comb begin
`ifdef MUX_SEQ_PINGPONG_EN
    dir_adv = dir_q;
    if (!dir_q) begin
      if (sel_q == SelLast) begin
        sel_adv = sel_q - SEL_W'(1);
        dir_adv = 1'b1;
      end else begin
        sel_adv = sel_q + SEL_W'(1);
      end
    end else begin
      if (sel_q == '0) begin
        sel_adv = SEL_W'(1);
        dir_adv = 1'b0;
      end else begin
        sel_adv = sel_q - SEL_W'(1);
      end
    end
`else
    sel_adv = sel_q + SEL_W'(1);  // natural wrap from last channel to 0
`endif
  end

  always_comb begin
    advance = ((state_d == StScan) && tick) || ((state_d == StManual) && btn_rise);
    sel_d   = sel_q;
    step_d  = 1'b0;
`ifdef MUX_SEQ_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (state_d == StIdle) begin
      sel_d = '0;
`ifdef MUX_SEQ_PINGPONG_EN
      dir_d = 1'b0;
`endif
    end else if (advance) begin
      sel_d  = sel_adv;
      step_d = 1'b1;
`ifdef MUX_SEQ_PINGPONG_EN
      dir_d  = dir_adv;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      sel_q      <= '0;
      step_q     <= 1'b0;
      btn_prev_q <= 1'b0;
`ifdef MUX_SEQ_PINGPONG_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sel_q      <= sel_d;
      step_q     <= step_d;
      btn_prev_q <= btn_db;
`ifdef MUX_SEQ_PINGPONG_EN
      dir_q      <= dir_d;
`endif
    end
  end

  // sw_en is itself a register, so sel and step_pulse are masked by it to drop
  // to 0 in the very cycle the enable falls rather than one clock later.
  assign sw_en      = sw_db;
  assign sel        = (state_d == StIdle) ? '0 : sel_q;
  assign step_pulse = step_q && (state_d != StIdle);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer with a cycle-level reference model.
module tb_mux_sel_sequencer;

  localparam int SelW     = 3;
  localparam int DivMax   = 9;
  localparam int DbCycles = 4;
  localparam int NumCh    = 1 << SelW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sw_raw = 1'b0;
  logic            btn_raw = 1'b0;
  logic            auto_mode = 1'b0;
  logic [SelW-1:0] sel;
  logic            sw_en, step_pulse, tick;

  int n_checks = 0;
  int n_fail   = 0;
  int g_steps  = 0;
  int g_ticks  = 0;
  int g_zero_steps = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(
    .SEL_W     (SelW),
    .DIV_W     (24),
    .DIV_MAX   (DivMax),
    .DB_W      (16),
    .DB_CYCLES (DbCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .auto_mode  (auto_mode),
    .sel        (sel),
    .sw_en      (sw_en),
    .step_pulse (step_pulse),
    .tick       (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw inputs reach the debouncer two clocks late; a level is accepted after
  // DbCycles consecutive disagreeing samples. The select is a position on a
  // sweep path: length NumCh (wrap) or 2*NumCh-2 (ping-pong).
  int m_sw_d1 = 0, m_sw_d2 = 0, m_sw_st = 0, m_sw_run = 0;
  int m_bt_d1 = 0, m_bt_d2 = 0, m_bt_st = 0, m_bt_run = 0;
  int m_pos = 0, m_step = 0, m_scan = 0, m_btn_prev = 0;

  function automatic int sweep_len();
`ifdef MUX_SEQ_PINGPONG_EN
    return 2 * NumCh - 2;
`else
    return NumCh;
`endif
  endfunction

  function automatic int pos_sel(input int p);
`ifdef MUX_SEQ_PINGPONG_EN
    return (p < NumCh) ? p : 2 * NumCh - 2 - p;
`else
    return p;
`endif
  endfunction

  // 0 idle, 1 scan, 2 manual
  function automatic int m_mode();
    if (m_sw_st == 0) return 0;
    return (auto_mode === 1'b1) ? 1 : 2;
  endfunction

  function automatic int m_tick();
    return (m_mode() == 1 && (m_scan % (DivMax + 1)) == DivMax) ? 1 : 0;
  endfunction

  task automatic db_step(input logic raw, inout int d1, inout int d2, inout int st,
                         inout int run);
    if (d2 != st) begin
      run++;
      if (run == DbCycles) begin
        st  = d2;
        run = 0;
      end
    end else begin
      run = 0;
    end
    d2 = d1;
    d1 = (raw === 1'b1) ? 1 : 0;
  endtask

  task automatic model_edge();
    int mode, tk, rise;
    if (rst === 1'b1) begin
      m_sw_d1 = 0; m_sw_d2 = 0; m_sw_st = 0; m_sw_run = 0;
      m_bt_d1 = 0; m_bt_d2 = 0; m_bt_st = 0; m_bt_run = 0;
      m_pos = 0; m_step = 0; m_scan = 0; m_btn_prev = 0;
      return;
    end
    mode   = m_mode();
    tk     = m_tick();
    rise   = (m_bt_st == 1 && m_btn_prev == 0) ? 1 : 0;
    m_step = 0;
    if (mode == 0) begin
      m_pos = 0;
    end else if ((mode == 1 && tk == 1) || (mode == 2 && rise == 1)) begin
      m_pos  = (m_pos + 1) % sweep_len();
      m_step = 1;
    end
    m_scan     = (mode == 1) ? m_scan + 1 : 0;
    m_btn_prev = m_bt_st;
    db_step(sw_raw, m_sw_d1, m_sw_d2, m_sw_st, m_sw_run);
    db_step(btn_raw, m_bt_d1, m_bt_d2, m_bt_st, m_bt_run);
  endtask

  // One clock: update model with the inputs about to be sampled, then compare
  // all outputs at the falling edge.
  task automatic cycle();
    int mode;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    mode = m_mode();
    check_eq("sw_en", sw_en, m_sw_st);
    check_eq("sel", sel, (mode == 0) ? 0 : pos_sel(m_pos));
    check_eq("step_pulse", step_pulse, (mode != 0 && m_step != 0) ? 1 : 0);
    check_eq("tick", tick, m_tick());
    if (step_pulse === 1'b1) begin
      g_steps++;
      if (sel == '0) g_zero_steps++;
    end
    if (tick === 1'b1) g_ticks++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_sw(input logic lvl, input int bound, output int n);
    n = 0;
    while (sw_en !== lvl && n < bound) begin
      cycle();
      n++;
    end
  endtask

  int n;
  int seen;
  int k;
  int cyc;
  int got[16];

  initial begin
    // Reset with switch already on: everything held at 0.
    rst = 1'b1; sw_raw = 1'b1; btn_raw = 1'b0; auto_mode = 1'b0;
    run(3);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_sw_en", sw_en, 0);
    check_eq("rst_step", step_pulse, 0);
    check_eq("rst_tick", tick, 0);
    rst = 1'b0;
    wait_sw(1'b1, 20, n);
    check_eq("sw_rise_latency", n, 6);
    sw_raw = 1'b0;
    wait_sw(1'b0, 20, n);
    check_eq("sw_fall_latency", n, 6);

    // Glitch of 3 cycles must be rejected.
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      sw_raw = (i < 3);
      cycle();
      if (sw_en === 1'b1) seen = 1;
    end
    check_eq("glitch_rejected", seen, 0);

    // Held high with auto scan.
    auto_mode = 1'b1;
    sw_raw = 1'b1;
    wait_sw(1'b1, 20, n);
    check_eq("sw_hold_latency", n, 6);
    g_steps = 0; g_ticks = 0; g_zero_steps = 0;
    run(90);
    check_eq("scan_ticks", g_ticks, 9);
    check_eq("scan_steps", g_steps, 9);
`ifdef MUX_SEQ_PINGPONG_EN
    check_eq("scan_zero_steps", g_zero_steps, 0);
`else
    check_eq("scan_wrap_to_0", g_zero_steps, 1);
`endif
    check_eq("scan_end_sel", sel, pos_sel(9 % sweep_len()));

    // Manual: three clean presses, then a short one.
    auto_mode = 1'b0;
    g_steps = 0; g_ticks = 0;
    for (int p = 0; p < 3; p++) begin
      btn_raw = 1'b1; run(8);
      btn_raw = 1'b0; run(8);
    end
    check_eq("manual_steps", g_steps, 3);
    check_eq("manual_ticks", g_ticks, 0);
    g_steps = 0;
    btn_raw = 1'b1; run(3);
    btn_raw = 1'b0; run(10);
    check_eq("short_press_steps", g_steps, 0);

    // Disable mid-scan once sel reaches 5.
    auto_mode = 1'b1;
    cyc = 0;
    while (!(m_mode() == 1 && pos_sel(m_pos) == 5) && cyc < 300) begin
      cycle();
      cyc++;
    end
    check_eq("reached_sel5", (m_mode() == 1 && pos_sel(m_pos) == 5) ? 1 : 0, 1);
    check_eq("sel_is_5", sel, 5);
    sw_raw = 1'b0;
    wait_sw(1'b0, 20, n);
    check_eq("disable_latency", n, 6);
    check_eq("disable_sel", sel, 0);
    check_eq("disable_step", step_pulse, 0);
    sw_raw = 1'b1;
    wait_sw(1'b1, 20, n);
    check_eq("reenable_sel", sel, 0);

    // Sweep order over 16 steps from a clean start.
    rst = 1'b1; run(2); rst = 1'b0;
    wait_sw(1'b1, 20, n);
    k = 0; cyc = 0;
    while (k < 16 && cyc < 250) begin
      cycle();
      cyc++;
      if (step_pulse === 1'b1) begin
        got[k] = int'(sel);
        k++;
      end
    end
    check_eq("sweep_count", k, 16);
    for (int i = 0; i < k; i++) begin
      check_eq("sweep_sel", got[i], pos_sel((i + 1) % sweep_len()));
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) sw_raw = ~sw_raw;
      if ($urandom_range(0, 7) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
